// File: rtl/key_pkg.sv
// ============================================================================
// Module      : key_pkg
// Description : Shared state type, default timing constants and helpers for
//               the key press classifier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package key_pkg;

    typedef enum logic [1:0] {
        WAIT_REL  = 2'd0,
        IDLE      = 2'd1,
        PRESSED   = 2'd2,
        LONG_HELD = 2'd3
    } key_state_t;

    localparam int unsigned c_long_cycles_dflt   = 1000;
    localparam int unsigned c_repeat_cycles_dflt = 200;

    function automatic logic key_is_held(input key_state_t state);
        return (state == PRESSED) || (state == LONG_HELD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/press_timer.sv
// ============================================================================
// Module      : press_timer
// Description : Saturating up-counter with clear, enable and a terminal-count
//               flag that is high while the count sits at LIMIT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module press_timer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [WIDTH-1:0] c_limit = WIDTH'(LIMIT);

    logic [WIDTH-1:0] r_count;
    logic             w_at_limit;

    assign w_at_limit = (r_count == c_limit);
    assign o_tc       = w_at_limit;

    // Clear wins over enable; counting stops at LIMIT so it can never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !w_at_limit) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/key_press_classifier.sv
// ============================================================================
// Module      : key_press_classifier
// Description : Classifies a debounced key level into press, short, long and
//               auto-repeat strobes. Auto-repeat built only with
//               KEY_PRESS_REPEAT_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module key_press_classifier
    import key_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = c_long_cycles_dflt,
    parameter int unsigned REPEAT_CYCLES = c_repeat_cycles_dflt
) (
    input  logic clk,
    input  logic rst,
    input  logic clean,
    output logic press_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam int unsigned c_hold_w = $clog2(LONG_CYCLES + 1);

    key_state_t r_state;
    key_state_t w_state_nxt;

    logic r_press;
    logic r_short;
    logic r_long;
    logic r_repeat;
    logic r_held;

    logic w_press;
    logic w_short;
    logic w_long;
    logic w_repeat;
    logic w_hold_clr;
    logic w_hold_en;
    logic w_hold_tc;
    logic w_rep_fire;

    if ((LONG_CYCLES < 2) || (LONG_CYCLES > 65535) ||
        (REPEAT_CYCLES < 1) || (REPEAT_CYCLES > 65535)) begin : g_bad_params
        $error("key_press_classifier: timing parameter out of range");
    end

    press_timer #(
        .WIDTH (c_hold_w),
        .LIMIT (LONG_CYCLES - 1)
    ) u_hold_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_hold_clr),
        .i_en  (w_hold_en),
        .o_tc  (w_hold_tc)
    );

`ifdef KEY_PRESS_REPEAT_EN
    localparam int unsigned c_rep_w = $clog2(REPEAT_CYCLES + 1);

    logic w_rep_en;
    logic w_rep_clr;
    logic w_rep_tc;

    // Held in clear outside LONG_HELD so the first period starts at long_press.
    assign w_rep_en   = (r_state == LONG_HELD) && clean;
    assign w_rep_fire = w_rep_en && w_rep_tc;
    assign w_rep_clr  = (r_state != LONG_HELD) || w_rep_fire;

    press_timer #(
        .WIDTH (c_rep_w),
        .LIMIT (REPEAT_CYCLES - 1)
    ) u_rep_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_rep_clr),
        .i_en  (w_rep_en),
        .o_tc  (w_rep_tc)
    );
`else
    assign w_rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= WAIT_REL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_press     = 1'b0;
        w_short     = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;
        w_hold_clr  = 1'b0;
        w_hold_en   = 1'b0;
        case (r_state)
            WAIT_REL: begin
                w_hold_clr = 1'b1;
                if (!clean) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                w_hold_clr = 1'b1;
                if (clean) begin
                    w_state_nxt = PRESSED;
                    w_press     = 1'b1;
                end
            end
            PRESSED: begin
                // Release is tested first so it beats the threshold.
                if (!clean) begin
                    w_state_nxt = IDLE;
                    w_short     = 1'b1;
                end else if (w_hold_tc) begin
                    w_state_nxt = LONG_HELD;
                    w_long      = 1'b1;
                end else begin
                    w_hold_en = 1'b1;
                end
            end
            LONG_HELD: begin
                if (!clean) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_repeat = w_rep_fire;
                end
            end
            default: begin
                w_state_nxt = WAIT_REL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_press  <= 1'b0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            r_press  <= w_press;
            r_short  <= w_short;
            r_long   <= w_long;
            r_repeat <= w_repeat;
            r_held   <= key_is_held(w_state_nxt);
        end
    end

    assign press_pulse  = r_press;
    assign short_press  = r_short;
    assign long_press   = r_long;
    assign repeat_pulse = r_repeat;
    assign held         = r_held;

endmodule

`default_nettype wire

// File: tb/tb_key_press_classifier.sv
// ============================================================================
// Module      : tb_key_press_classifier
// Description : Scoreboard bench for key_press_classifier (LONG=10, REPEAT=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_key_press_classifier;

    localparam int c_long = 10;
    localparam int c_rep  = 4;

    localparam int c_k_press = 0;
    localparam int c_k_short = 1;
    localparam int c_k_long  = 2;
    localparam int c_k_rep   = 3;

    typedef struct {
        int kind;
        int when;
    } ev_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic clean = 1'b0;
    logic press_pulse;
    logic short_press;
    logic long_press;
    logic repeat_pulse;
    logic held;

    int  cyc      = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    bit  mon_en   = 1'b0;
    ev_t exp_q[$];

    key_press_classifier #(
        .LONG_CYCLES   (c_long),
        .REPEAT_CYCLES (c_rep)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clean        (clean),
        .press_pulse  (press_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .held         (held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int when);
        ev_t e;
        e.kind = kind;
        e.when = when;
        exp_q.push_back(e);
    endtask

    // Every strobe the DUT raises must match the next queued expectation.
    always @(negedge clk) begin
        logic [3:0] s;
        ev_t        e;
        if (mon_en) begin
            s = {repeat_pulse, long_press, short_press, press_pulse};
            check("one_strobe_max", int'($countones(s) <= 1), 1);
            for (int k = 0; k < 4; k++) begin
                if (s[k]) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", k, -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("strobe_kind", k, e.kind);
                        check("strobe_cycle", cyc, e.when);
                    end
                end
            end
        end
    end

    task automatic check_all_low(input string tag);
        check({tag, "_press"},  int'(press_pulse),  0);
        check({tag, "_short"},  int'(short_press),  0);
        check({tag, "_long"},   int'(long_press),   0);
        check({tag, "_repeat"}, int'(repeat_pulse), 0);
        check({tag, "_held"},   int'(held),         0);
    endtask

    // Hold clean high for h sampled edges starting from IDLE, then release.
    task automatic press(input int h);
        int t0;
        int lt;
        t0 = cyc;
        expect_ev(c_k_press, t0 + 1);
        if (h >= c_long + 1) begin
            lt = t0 + 1 + c_long;
            expect_ev(c_k_long, lt);
`ifdef KEY_PRESS_REPEAT_EN
            for (int t = lt + c_rep; t <= t0 + h; t += c_rep) begin
                expect_ev(c_k_rep, t);
            end
`endif
        end else begin
            expect_ev(c_k_short, t0 + h + 1);
        end
        clean = 1'b1;
        repeat (h) @(negedge clk);
        check("held_while_pressed", int'(held), 1);
        clean = 1'b0;
        @(negedge clk);
        check("held_after_release", int'(held), 0);
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int t0;
        rst   = 1'b1;
        clean = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_low("reset");
        rst    = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        press(5);
        press(20);
        press(25);
        press(10);
        press(11);
        press(1);

        // Key already down across reset release: nothing until it is let go.
        rst   = 1'b0;
        clean = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("waitrel_no_strobe", exp_q.size(), 0);
        check("waitrel_held", int'(held), 0);
        clean = 1'b0;
        @(negedge clk);
        press(3);

        // Reset mid-press aborts immediately without any strobe.
        t0 = cyc;
        expect_ev(c_k_press, t0 + 1);
        clean = 1'b1;
        repeat (3) @(negedge clk);
        check("midpress_held", int'(held), 1);
        #2 rst = 1'b0;
        #1 check_all_low("async_reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_no_strobe", exp_q.size(), 0);
        check("abort_held", int'(held), 0);
        clean = 1'b0;
        @(negedge clk);
        press(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
